can_tx_scheduler: RTL and testbench

Periodic transmit scheduler for the CAN node SoC peripheral set. It derives a base tick from the system clock with a free-running down-counting prescaler, and keeps one programmable period counter per message slot. Each expiry is turned into a transmit request, and requests are arbitrated onto a single req/ack channel toward the CAN transmit controller. Slots are configured by the CPU through a simple write port.

---
 rtl/can_tx_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler -- periodic CAN transmit scheduler.
//
// A free-running down-counting prescaler produces a one-cycle base tick
// every TICK_DIV clocks. Each message slot has a programmable period
// counter, measured in ticks. When a slot's counter expires, the slot's
// pending flag is set. A two-state arbiter grants the lowest-index pending
// slot on a single req/ack channel toward the CAN transmit controller.
//
// Optional feature: define TX_SCHED_OVERRUN_EN to build sticky per-slot
// overrun flags. An overrun is flagged when a slot expires while its
// previous request is still pending. Without the macro, overrun is
// constant 0 and clr_overrun is ignored.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   cfg_we/cfg_slot    one-cycle slot configuration write strobe and slot
//                      address; the written period is cfg_period and the
//                      enable is cfg_enable
//   tick               base tick pulse
//   tx_req/tx_slot     transmit request and granted slot
//   tx_ack             controller accepted the request
//   pending            per-slot due flags
//   overrun            sticky per-slot overrun flags
//   clr_overrun        per-bit clear of overrun

// Per-slot period counter with pending / overrun flags.
// Same-cycle priority on one slot: a config write beats a tick, and a
// tick set beats an ack clear.
module can_tx_slot #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             cfg_wr_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic             cfg_enable_i,
  input  logic             ack_clr_i,
  input  logic             clr_ovr_i,
  output logic             pending_o,
  output logic             overrun_o
);
  logic             en_q, en_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic             expire;

  assign expire = tick_i & en_q & (cnt_q == '0);

  always_comb begin
    en_d     = en_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    if (cfg_wr_i) begin
      pend_d = 1'b0;
      if (cfg_enable_i && cfg_period_i != '0) begin
        en_d     = 1'b1;
        period_d = cfg_period_i;
        cnt_d    = cfg_period_i - CNT_W'(1);
      end else begin
        en_d = 1'b0;
      end
    end else begin
      if (tick_i && en_q) cnt_d = (cnt_q == '0) ? period_q - CNT_W'(1) : cnt_q - CNT_W'(1);
      if (expire)         pend_d = 1'b1;
      else if (ack_clr_i) pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      period_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign pending_o = pend_q;

`ifdef TX_SCHED_OVERRUN_EN
  logic ovr_q, ovr_d;
  // A set wins over a simultaneous clear, so a fresh overrun is never lost.
  always_comb begin
    ovr_d = ovr_q & ~clr_ovr_i;
    if (!cfg_wr_i && expire && pend_q && !ack_clr_i) ovr_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end
  assign overrun_o = ovr_q;
`else
  logic unused_clr_ovr;
  assign unused_clr_ovr = clr_ovr_i;
  assign overrun_o      = 1'b0;
`endif
endmodule

module can_tx_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int TICK_DIV  = 50000,
  parameter int CNT_W     = 16,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic                 cfg_enable,
  output logic                 tick,
  output logic                 tx_req,
  output logic [SLOT_W-1:0]    tx_slot,
  input  logic                 tx_ack,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [NUM_SLOTS-1:0] overrun,
  input  logic [NUM_SLOTS-1:0] clr_overrun
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Prescaler: tick fires while the count sits at zero, then reloads.
  logic [31:0] presc_q, presc_d;
  assign tick    = (presc_q == '0);
  assign presc_d = tick ? 32'(TICK_DIV - 1) : presc_q - 32'd1;

  always_ff @(posedge clk) begin
    if (rst) presc_q <= 32'(TICK_DIV - 1);
    else     presc_q <= presc_d;
  end

  // Slot array
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic cfg_wr, ack_clr;
    assign cfg_wr  = cfg_we & (cfg_slot == SLOT_W'(g));
    assign ack_clr = tx_req & tx_ack & (tx_slot == SLOT_W'(g));
    can_tx_slot #(.CNT_W(CNT_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .cfg_wr_i    (cfg_wr),
      .cfg_period_i(cfg_period),
      .cfg_enable_i(cfg_enable),
      .ack_clr_i   (ack_clr),
      .clr_ovr_i   (clr_overrun[g]),
      .pending_o   (pending[g]),
      .overrun_o   (overrun[g])
    );
  end

  // Arbiter: lowest-index pending slot wins. The grant is held until acked;
  // reconfiguring the granted slot does not abort it.
  logic [0:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d, low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) if (pending[i]) low_idx = SLOT_W'(i);
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE: if (|pending) begin
        slot_d  = low_idx;
        state_d = S_REQ;
      end
      default: if (tx_ack) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  assign tx_req  = (state_q == S_REQ);
  assign tx_slot = slot_q;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler (TICK_DIV=4, NUM_SLOTS=4, CNT_W=8).
// Cycle k is the interval after the k-th clock edge following reset
// release. Inputs are driven and outputs sampled 1 time unit after the edge.
module tb_can_tx_scheduler;
`ifdef TX_SCHED_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_enable, tx_ack;
  logic [1:0] cfg_slot;
  logic [7:0] cfg_period;
  logic       tick, tx_req;
  logic [1:0] tx_slot;
  logic [3:0] pending, overrun, clr_overrun;

  can_tx_scheduler #(.NUM_SLOTS(4), .TICK_DIV(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_period(cfg_period), .cfg_enable(cfg_enable), .tick(tick),
    .tx_req(tx_req), .tx_slot(tx_slot), .tx_ack(tx_ack), .pending(pending),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int k, t0;
  int passed = 0, failed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic cyc(input logic er, input logic [1:0] es, input logic [3:0] ep,
                     input logic [3:0] eo);
    chk("tick", 32'(tick), 32'((k - t0) % 4 == 3));
    chk("tx_req", 32'(tx_req), 32'(er));
    if (er) chk("tx_slot", 32'(tx_slot), 32'(es));
    chk("pending", 32'(pending), 32'(ep));
    chk("overrun", 32'(overrun), 32'(eo));
  endtask

  task automatic idle_in();
    cfg_we = 0; cfg_enable = 0; cfg_slot = 0; cfg_period = 0;
    tx_ack = 0; clr_overrun = 0; rst = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    k = -3; t0 = 0;
    repeat (3) step();
    rst = 0;

    // 1: no config, ticks at 3,7,11,...; nothing requested
    while (k < 100) begin
      idle_in();
      cyc(0, 0, 4'b0000, 4'b0000);
      step();
    end

    // 2: slot 2 period 3, ack first req cycle; ignored ack in IDLE at 139
    while (k <= 140) begin
      idle_in();
      cfg_we = (k == 100) || (k == 140); cfg_slot = 2; cfg_period = 3;
      cfg_enable = (k == 100);
      tx_ack = (k inside {113, 125, 137, 139});
      cyc(k inside {113, 125, 137}, 2,
          (k inside {112, 113, 124, 125, 136, 137}) ? 4'b0100 : 4'b0000, 4'b0000);
      step();
    end

    // 3: slots 3 and 0 period 2 written back to back; grant 0 then 3
    while (k <= 158) begin
      idle_in();
      cfg_we = (k inside {144, 145, 157, 158});
      cfg_slot = (k == 144 || k == 158) ? 2'd3 : 2'd0;
      cfg_period = 2; cfg_enable = (k < 150);
      tx_ack = (k == 153 || k == 155);
      cyc(k == 153 || k == 155, (k == 153) ? 2'd0 : 2'd3,
          (k inside {152, 153}) ? 4'b1001 : (k inside {154, 155}) ? 4'b1000 : 4'b0000,
          4'b0000);
      step();
    end

    // 4: slot 1 period 1, ack withheld 3 ticks; clear overrun; disable on
    //    a tick cycle (config write beats the tick set)
    while (k <= 183) begin
      idle_in();
      cfg_we = (k == 160 || k == 179); cfg_slot = 1; cfg_period = 1;
      cfg_enable = (k == 160);
      tx_ack = (k == 177);
      clr_overrun = (k == 178) ? 4'b0010 : 4'b0000;
      cyc(k inside {[165:177]}, 1,
          (k inside {[164:177]}) ? 4'b0010 : 4'b0000,
          (OVR_ON && (k inside {[168:178]})) ? 4'b0010 : 4'b0000);
      step();
    end

    // 5: slot 0 in REQ is disabled; grant held until ack, then silence
    while (k <= 210) begin
      idle_in();
      cfg_we = (k == 184 || k == 190); cfg_slot = 0; cfg_period = 1;
      cfg_enable = (k == 184);
      tx_ack = (k == 194);
      cyc(k inside {[189:194]}, 0,
          (k inside {[188:190]}) ? 4'b0001 : 4'b0000, 4'b0000);
      step();
    end

    // 6: reset during REQ for slot 2; prescaler restarts
    while (k <= 235) begin
      idle_in();
      if (k == 222) t0 = 222;
      cfg_we = (k == 211); cfg_slot = 2; cfg_period = 1; cfg_enable = 1;
      rst = (k == 221);
      cyc(k inside {[217:221]}, 2,
          (k inside {[216:221]}) ? 4'b0100 : 4'b0000,
          (OVR_ON && (k inside {[220:221]})) ? 4'b0100 : 4'b0000);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
